// File: rtl/opamp_pwm_stim.sv
// -----------------------------------------------------------------------------
// opamp_pwm_stim
//
// PWM stimulus generator for the two-stage op-amp bench. The op-amp input is
// driven through an external RC low-pass filter. The PWM period is fixed at
// 2^W clocks. The duty cycle comes from one of two sources:
//   - a value loaded over a valid/ready handshake, or
//   - an automatic triangle sweep (ramp) used for slew and linearity runs.
// A duty change only takes effect at a period boundary. This means the
// filtered analog level never sees a torn period.
//
// Ports:
//   clk          system clock
//   rst          asynchronous active-high reset
//   ena          run enable; 0 parks the generator (output low, counter at MAX)
//   load_valid   duty load request
//   load_data    duty value to load, 0..MAX
//   load_ready   high while the single pending slot is empty
//   ramp_en      auto-sweep enable
//   ramp_step    sweep increment applied once per period
//   pwm_out      registered PWM output
//   period_tick  registered one-cycle pulse on the first cycle of each period
//   ramp_dir     sweep direction (0 = up, 1 = down)
//   duty_q       duty currently in effect
// -----------------------------------------------------------------------------
module opamp_pwm_stim #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         ena,
    input  logic         load_valid,
    input  logic [W-1:0] load_data,
    output logic         load_ready,
    input  logic         ramp_en,
    input  logic [W-1:0] ramp_step,
    output logic         pwm_out,
    output logic         period_tick,
    output logic         ramp_dir,
    output logic [W-1:0] duty_q
);

    localparam logic [W-1:0] MAX = {W{1'b1}};

    logic [W-1:0] cnt_reg,           cnt_next;
    logic [W-1:0] duty_reg,          duty_next;
    logic [W-1:0] pending_reg,       pending_next;
    logic         pending_valid_reg, pending_valid_next;
    logic         ramp_dir_reg,      ramp_dir_next;
    logic         pwm_reg,           pwm_next;
    logic         tick_reg,          tick_next;

    logic         boundary;
    logic         xfer;
    logic         apply_pending;
    logic [W:0]   sum_up;
    logic [W:0]   sum_dn;
    logic [W-1:0] ramp_duty;
    logic         ramp_dir_new;

    assign load_ready  = !pending_valid_reg;
    assign xfer        = load_valid && !pending_valid_reg;

    assign pwm_out     = pwm_reg;
    assign period_tick = tick_reg;
    assign ramp_dir    = ramp_dir_reg;
    assign duty_q      = duty_reg;

    // The sweep uses one extra bit. Overflow past MAX and underflow below 0
    // are then visible as the top bit, or as a compare against the widened MAX.
    always_comb begin
        sum_up       = {1'b0, duty_reg} + {1'b0, ramp_step};
        sum_dn       = {1'b0, duty_reg} - {1'b0, ramp_step};
        ramp_duty    = duty_reg;
        ramp_dir_new = ramp_dir_reg;
        if (ramp_step != '0) begin
            if (!ramp_dir_reg) begin
                // Reaching MAX exactly also turns the sweep around.
                if (sum_up >= {1'b0, MAX}) begin
                    ramp_duty    = MAX;
                    ramp_dir_new = 1'b1;
                end else begin
                    ramp_duty    = sum_up[W-1:0];
                end
            end else begin
                // A borrow into the top bit means the result went negative.
                if (sum_dn[W] || (sum_dn == '0)) begin
                    ramp_duty    = '0;
                    ramp_dir_new = 1'b0;
                end else begin
                    ramp_duty    = sum_dn[W-1:0];
                end
            end
        end
    end

    always_comb begin
        // When parked, the counter is held at MAX. The first enabled edge
        // therefore wraps it to 0 and is a boundary.
        cnt_next = ena ? (cnt_reg + 1'b1) : MAX;
        boundary = ena && (cnt_next == '0);

        // When disabled, there is no period to protect, so a pending value
        // is applied on the very next edge.
        apply_pending = pending_valid_reg && (boundary || !ena);

        duty_next     = duty_reg;
        ramp_dir_next = ramp_dir_reg;
        if (apply_pending) begin
            duty_next = pending_reg;
        end else if (boundary && ramp_en) begin
            duty_next     = ramp_duty;
            ramp_dir_next = ramp_dir_new;
        end

        // A transfer can only happen while the slot is empty. It therefore
        // never coincides with apply_pending. A value accepted on a boundary
        // edge waits for the next boundary.
        pending_next       = xfer ? load_data : pending_reg;
        pending_valid_next = pending_valid_reg;
        if (xfer) begin
            pending_valid_next = 1'b1;
        end else if (apply_pending) begin
            pending_valid_next = 1'b0;
        end

        pwm_next  = ena && (cnt_next < duty_next);
        tick_next = boundary;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_reg           <= MAX;
            duty_reg          <= '0;
            pending_reg       <= '0;
            pending_valid_reg <= 1'b0;
            ramp_dir_reg      <= 1'b0;
            pwm_reg           <= 1'b0;
            tick_reg          <= 1'b0;
        end else begin
            cnt_reg           <= cnt_next;
            duty_reg          <= duty_next;
            pending_reg       <= pending_next;
            pending_valid_reg <= pending_valid_next;
            ramp_dir_reg      <= ramp_dir_next;
            pwm_reg           <= pwm_next;
            tick_reg          <= tick_next;
        end
    end

endmodule

// File: tb/tb_opamp_pwm_stim.sv
// -----------------------------------------------------------------------------
// tb_opamp_pwm_stim
//
// Directed testbench for opamp_pwm_stim with W = 8 (period = 256 clocks).
// Expected values are computed by hand from the PWM, double-buffer and
// triangle-sweep rules. Outputs are sampled 1 time unit after each rising edge.
// -----------------------------------------------------------------------------
module tb_opamp_pwm_stim;

    logic       clk = 1'b0;
    logic       rst;
    logic       ena;
    logic       load_valid;
    logic [7:0] load_data;
    logic       load_ready;
    logic       ramp_en;
    logic [7:0] ramp_step;
    logic       pwm_out;
    logic       period_tick;
    logic       ramp_dir;
    logic [7:0] duty_q;

    int n_cmp = 0;
    int n_bad = 0;

    // Results of the most recent run() call
    int   r_high;
    int   r_tick;
    int   r_rdy;
    logic first_tick;
    logic first_pwm;
    logic last_pwm;

    opamp_pwm_stim #(.W(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .ena         (ena),
        .load_valid  (load_valid),
        .load_data   (load_data),
        .load_ready  (load_ready),
        .ramp_en     (ramp_en),
        .ramp_step   (ramp_step),
        .pwm_out     (pwm_out),
        .period_tick (period_tick),
        .ramp_dir    (ramp_dir),
        .duty_q      (duty_q)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end else begin
            $display("ok   %s: %0d", tag, got);
        end
    endtask

    // Advance n clock edges.
    // Counts pwm-high cycles, ticks and load_ready-high cycles.
    task automatic run(input int n);
        r_high = 0;
        r_tick = 0;
        r_rdy  = 0;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            if (i == 0) begin
                first_tick = period_tick;
                first_pwm  = pwm_out;
            end
            r_high += int'(pwm_out);
            r_tick += int'(period_tick);
            r_rdy  += int'(load_ready);
        end
        last_pwm = pwm_out;
    endtask

    // Ramp expectations: duty and direction after each period
    int exp_duty [7] = '{100, 200, 255, 155, 55, 0, 100};
    int exp_dir  [7] = '{0, 0, 1, 1, 1, 0, 0};
    int h1;
    int h2;

    initial begin
        rst        = 1'b1;
        ena        = 1'b0;
        load_valid = 1'b0;
        load_data  = '0;
        ramp_en    = 1'b0;
        ramp_step  = '0;
        #1;
        check("rst_pwm",   pwm_out,     0);
        check("rst_tick",  period_tick, 0);
        check("rst_ready", load_ready,  1);
        check("rst_duty",  duty_q,      0);
        check("rst_dir",   ramp_dir,    0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Load 64 while disabled: accepted at one edge, applied at the next
        load_valid = 1'b1;
        load_data  = 8'd64;
        run(1);
        load_valid = 1'b0;
        check("dis_load_ready", load_ready, 0);
        check("dis_load_duty0", duty_q,     0);
        run(1);
        check("dis_load_duty64", duty_q,     64);
        check("dis_load_ready1", load_ready, 1);
        check("dis_pwm_low",     pwm_out,    0);

        // Enable: first edge is a boundary, and the period has 64 high cycles
        ena = 1'b1;
        run(256);
        check("p64_first_tick", first_tick, 1);
        check("p64_first_pwm",  first_pwm,  1);
        check("p64_high",       r_high,     64);
        check("p64_ticks",      r_tick,     1);
        run(256);
        check("p64b_first_tick", first_tick, 1);
        check("p64b_high",       r_high,     64);
        check("p64b_ticks",      r_tick,     1);

        // Duty 0. The load lands on a boundary edge, so it applies one period later.
        load_valid = 1'b1;
        load_data  = 8'd0;
        run(1);
        load_valid = 1'b0;
        check("d0_loadedge_duty", duty_q, 64);
        run(255);
        check("d0_prev_high", r_high, 63);
        run(256);
        check("d0_high", r_high, 0);
        check("d0_duty", duty_q, 0);

        // Duty 255: high everywhere except cnt = 255
        load_valid = 1'b1;
        load_data  = 8'd255;
        run(1);
        load_valid = 1'b0;
        run(255);
        run(256);
        check("d255_high",     r_high,   255);
        check("d255_last_pwm", last_pwm, 0);
        check("d255_ticks",    r_tick,   1);

        // Double buffering: duty 64 active, load 200 mid-period, then hold a load of 10
        load_valid = 1'b1;
        load_data  = 8'd64;
        run(1);
        load_valid = 1'b0;
        run(255);
        run(100);
        h1 = r_high;
        check("db_duty64", duty_q, 64);
        load_valid = 1'b1;
        load_data  = 8'd200;
        run(1);
        h1 += r_high;
        load_data = 8'd10;
        check("db_ready_low", load_ready, 0);
        run(155);
        h1 += r_high;
        check("db_ready_held_low", r_rdy, 0);
        check("db_period1_high",   h1,    64);
        check("db_duty_still64",   duty_q, 64);
        run(1);
        h2 = r_high;
        check("db_bnd_duty200", duty_q,      200);
        check("db_bnd_ready",   load_ready,  1);
        check("db_bnd_tick",    period_tick, 1);
        run(1);
        h2 += r_high;
        load_valid = 1'b0;
        check("db_10_accepted", load_ready, 0);
        check("db_10_pending",  duty_q,     200);
        run(254);
        h2 += r_high;
        check("db_period2_high", h2, 200);
        run(256);
        check("db_period3_high", r_high, 10);
        check("db_duty10",       duty_q, 10);

        // Asynchronous reset right after a boundary, with a value pending
        load_valid = 1'b1;
        load_data  = 8'd77;
        run(1);
        load_valid = 1'b0;
        check("ar_pre_tick",  period_tick, 1);
        check("ar_pre_pwm",   pwm_out,     1);
        check("ar_pre_ready", load_ready,  0);
        #2;
        rst = 1'b1;
        #1;
        check("ar_pwm",   pwm_out,     0);
        check("ar_tick",  period_tick, 0);
        check("ar_ready", load_ready,  1);
        check("ar_duty",  duty_q,      0);

        // Ramp from reset with step 100
        ramp_en   = 1'b1;
        ramp_step = 8'd100;
        ena       = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int p = 0; p < 7; p++) begin
            run(256);
            check($sformatf("ramp%0d_tick", p), first_tick, 1);
            check($sformatf("ramp%0d_high", p), r_high, exp_duty[p]);
            check($sformatf("ramp%0d_duty", p), duty_q, exp_duty[p]);
            check($sformatf("ramp%0d_dir",  p), ramp_dir, exp_dir[p]);
        end

        // Disable mid-period, load while disabled, then re-enable
        ramp_en = 1'b0;
        run(10);
        check("en_mid_pwm", pwm_out, 1);
        ena = 1'b0;
        run(1);
        check("dis_pwm",  pwm_out,     0);
        check("dis_tick", period_tick, 0);
        load_valid = 1'b1;
        load_data  = 8'd30;
        run(1);
        load_valid = 1'b0;
        check("dis30_pending", duty_q, 100);
        run(1);
        check("dis30_duty", duty_q,   30);
        check("dis30_dir",  ramp_dir, 0);
        ena = 1'b1;
        run(256);
        check("reen_first_tick", first_tick, 1);
        check("reen_first_pwm",  first_pwm,  1);
        check("reen_high",       r_high,     30);
        check("reen_ticks",      r_tick,     1);
        run(1);
        check("reen_next_tick", period_tick, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
